// File: rtl/dma_periph_pkg.sv
// Shared types and constants for the DMA peripheral-side handshake endpoint.
package dma_periph_pkg;

   // Handshake FSM states.
   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StXfer,
      StRelease,
      StDone
   } state_e;

   // Transfer mode as programmed into the channel; 2'b11 behaves as single.
   typedef logic [1:0] mode_t;
   localparam mode_t MODE_DEMAND = 2'b00;
   localparam mode_t MODE_SINGLE = 2'b01;
   localparam mode_t MODE_BLOCK  = 2'b10;

   // Strobe edge pattern as {previous, current}; active-low strobes complete on release.
   localparam logic [1:0] STROBE_RISE = 2'b01;

   function automatic logic strobe_rise(input logic prev, input logic cur);
      return {prev, cur} == STROBE_RISE;
   endfunction

endpackage

// File: rtl/dma_sync_fifo.sv
// Single-clock FIFO with occupancy count; a pop in the same cycle frees room for a push.
module dma_sync_fifo #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] data_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [CNT_W-1:0]  count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic              do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   // Pop is evaluated first so a full FIFO can accept a push alongside a pop.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   // Storage array; contents are don't-care while unoccupied.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/dma_periph_handshake.sv
// Peripheral end of a DREQ/DACK DMA handshake: requests service for a local device and
// moves bytes between local TX/RX FIFOs and the device bus on IOR_N/IOW_N strobes.
module dma_periph_handshake
   import dma_periph_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic              dir_i,
   input  logic [1:0]        mode_i,
   input  logic              dreq_pol_i,
   input  logic              dack_pol_i,
   output logic              dreq_o,
   input  logic              dack_i,
   input  logic              ior_n_i,
   input  logic              iow_n_i,
   input  logic              eop_n_i,
   input  logic [DATA_W-1:0] db_in_i,
   output logic [DATA_W-1:0] db_out_o,
   output logic              db_oe_o,
   input  logic              tx_valid_i,
   output logic              tx_ready_o,
   input  logic [DATA_W-1:0] tx_data_i,
   output logic              rx_valid_o,
   input  logic              rx_ready_i,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              tc_o,
   output logic              err_o
);

   state_e            state_q, state_d;
   logic              dreq_q, dreq_d;
   logic              tc_q, tc_d;
   logic              err_q;
   logic              ior_q, iow_q;
   logic [DATA_W-1:0] db_in_q, last_q;

   logic              dack_act, xfer_done, svc, svc_nxt;
   logic              tx_push, tx_pop, tx_full, tx_empty;
   logic              rx_push, rx_pop, rx_full, rx_empty;
   logic [DATA_W-1:0] tx_head;
   logic [CNT_W-1:0]  tx_count, rx_count, tx_cnt_nxt, rx_cnt_nxt;

   assign dack_act  = dack_i ^ dack_pol_i;
   assign dreq_o    = dreq_q ^ dreq_pol_i;
   assign xfer_done = dack_act & (dir_i ? strobe_rise(iow_q, iow_n_i)
                                        : strobe_rise(ior_q, ior_n_i));

   assign tx_push    = tx_valid_i & ~tx_full;
   assign tx_pop     = xfer_done & ~dir_i;
   assign tx_ready_o = ~tx_full;
   assign rx_push    = xfer_done & dir_i;
   assign rx_pop     = rx_valid_o & rx_ready_i;
   assign rx_valid_o = ~rx_empty;

   // Occupancy after this cycle's traffic, so demand mode drops DREQ right after the last byte.
   assign tx_cnt_nxt = tx_count + CNT_W'(tx_push) - CNT_W'(tx_pop & ~tx_empty);
   assign rx_cnt_nxt = rx_count + CNT_W'(rx_push & (~rx_full | rx_pop)) - CNT_W'(rx_pop);
   assign svc        = dir_i ? ~rx_full : ~tx_empty;
   assign svc_nxt    = dir_i ? (rx_cnt_nxt != CNT_W'(DEPTH)) : (tx_cnt_nxt != '0);

   assign db_oe_o  = dack_act & ~ior_n_i & ~dir_i;
   assign db_out_o = tx_empty ? last_q : tx_head;
   assign tc_o     = tc_q;
   assign err_o    = err_q;

   dma_sync_fifo #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_tx_fifo (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .push_i (tx_push),
      .pop_i  (tx_pop),
      .data_i (tx_data_i),
      .data_o (tx_head),
      .full_o (tx_full),
      .empty_o(tx_empty),
      .count_o(tx_count)
   );

   dma_sync_fifo #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_rx_fifo (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .push_i (rx_push),
      .pop_i  (rx_pop),
      .data_i (db_in_q),
      .data_o (rx_data_o),
      .full_o (rx_full),
      .empty_o(rx_empty),
      .count_o(rx_count)
   );

   // Handshake FSM next state; end-of-process during DACK overrides everything.
   always_comb begin
      state_d = state_q;
      dreq_d  = dreq_q;
      tc_d    = tc_q;
      unique case (state_q)
         StIdle: begin
            if (en_i && svc) begin
               state_d = StReq;
               dreq_d  = 1'b1;
            end
         end
         StReq: begin
            if (!en_i) begin
               state_d = StRelease;
               dreq_d  = 1'b0;
            end else if (dack_act) begin
               state_d = StXfer;
               if (mode_i == MODE_BLOCK) dreq_d = 1'b0;
            end
         end
         StXfer: begin
            if (!en_i) begin
               state_d = StRelease;
               dreq_d  = 1'b0;
            end else begin
               case (mode_i)
                  MODE_DEMAND: begin
                     if (!svc_nxt) begin
                        state_d = StRelease;
                        dreq_d  = 1'b0;
                     end
                  end
                  MODE_BLOCK: begin
                     dreq_d = 1'b0;
                     if (!dack_act) state_d = StRelease;
                  end
                  default: begin
                     if (xfer_done) begin
                        state_d = StRelease;
                        dreq_d  = 1'b0;
                     end
                  end
               endcase
            end
         end
         StRelease: begin
            dreq_d = 1'b0;
            if (!dack_act) state_d = StIdle;
         end
         StDone: begin
            dreq_d = 1'b0;
            if (!en_i) begin
               state_d = StIdle;
               tc_d    = 1'b0;
            end
         end
         default: begin
            state_d = StIdle;
            dreq_d  = 1'b0;
         end
      endcase
      if (dack_act && !eop_n_i) begin
         state_d = StDone;
         dreq_d  = 1'b0;
         tc_d    = 1'b1;
      end
   end

   // State, sticky flags, strobe history, bus capture and the held DB_OUT value.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         dreq_q  <= 1'b0;
         tc_q    <= 1'b0;
         err_q   <= 1'b0;
         ior_q   <= 1'b1;
         iow_q   <= 1'b1;
         db_in_q <= '0;
         last_q  <= '0;
      end else begin
         state_q <= state_d;
         dreq_q  <= dreq_d;
         tc_q    <= tc_d;
         ior_q   <= ior_n_i;
         iow_q   <= iow_n_i;
         db_in_q <= db_in_i;
         if ((tx_pop && tx_empty) || (rx_push && rx_full && !rx_pop)) err_q <= 1'b1;
         // Underflow pops drive zero; otherwise remember the byte just handed out.
         if (tx_pop) last_q <= tx_empty ? '0 : tx_head;
      end
   end

endmodule

// File: tb/tb_dma_periph_handshake.sv
// Directed bench for dma_periph_handshake with hand-computed expectations.
module tb_dma_periph_handshake;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       dir = 1'b0;
   logic [1:0] mode = 2'b00;
   logic       dreq_pol = 1'b0;
   logic       dack_pol = 1'b0;
   logic       dreq;
   logic       dack = 1'b0;
   logic       ior_n = 1'b1;
   logic       iow_n = 1'b1;
   logic       eop_n = 1'b1;
   logic [7:0] db_in = 8'h00;
   logic [7:0] db_out;
   logic       db_oe;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] tx_data = 8'h00;
   logic       rx_valid;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       tc;
   logic       err;

   int n_pass = 0;
   int n_total = 0;
   int dir_errs = 0;
   logic dir_prev = 1'b0;

   always #5 clk = ~clk;

   dma_periph_handshake #(
      .DATA_W(8),
      .DEPTH (8),
      .CNT_W (4)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .en_i      (en),
      .dir_i     (dir),
      .mode_i    (mode),
      .dreq_pol_i(dreq_pol),
      .dack_pol_i(dack_pol),
      .dreq_o    (dreq),
      .dack_i    (dack),
      .ior_n_i   (ior_n),
      .iow_n_i   (iow_n),
      .eop_n_i   (eop_n),
      .db_in_i   (db_in),
      .db_out_o  (db_out),
      .db_oe_o   (db_oe),
      .tx_valid_i(tx_valid),
      .tx_ready_o(tx_ready),
      .tx_data_i (tx_data),
      .rx_valid_o(rx_valid),
      .rx_ready_i(rx_ready),
      .rx_data_o (rx_data),
      .tc_o      (tc),
      .err_o     (err)
   );

   // DIR must stay static while the channel is enabled.
   always @(posedge clk) begin
      if (en) begin
         assert (dir === dir_prev) else begin
            dir_errs++;
            $error("FAIL dir_change: DIR=%0b while EN=1, previous DIR=%0b", dir, dir_prev);
         end
      end
      dir_prev <= dir;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
   endtask

   task automatic push_tx(input logic [7:0] d);
      tx_valid = 1'b1;
      tx_data  = d;
      cyc(1);
      tx_valid = 1'b0;
   endtask

   // IOR pulse: checks the driven byte while the strobe is low; optional EOP on release.
   task automatic ior_pulse(input string tag, input logic [7:0] exp, input logic eop_on_rise);
      ior_n = 1'b0;
      #1;
      chk1({tag, "_oe"}, db_oe, 1'b1);
      chk8({tag, "_db"}, db_out, exp);
      cyc(2);
      ior_n = 1'b1;
      if (eop_on_rise) eop_n = 1'b0;
      cyc(1);
      eop_n = 1'b1;
   endtask

   task automatic iow_pulse(input logic [7:0] d);
      iow_n = 1'b0;
      db_in = d;
      cyc(2);
      iow_n = 1'b1;
      cyc(1);
   endtask

   initial begin
      // Reset state.
      cyc(2);
      rst = 1'b0;
      cyc(1);
      chk1("rst_dreq", dreq, 1'b0);
      chk1("rst_oe", db_oe, 1'b0);
      chk8("rst_dbout", db_out, 8'h00);
      chk1("rst_tc", tc, 1'b0);
      chk1("rst_err", err, 1'b0);
      chk1("rst_txready", tx_ready, 1'b1);
      chk1("rst_rxvalid", rx_valid, 1'b0);

      // Demand mode, device-to-memory, active-high pins.
      en = 1'b1;
      push_tx(8'hA1);
      chk1("dem_dreq_lat1", dreq, 1'b0);
      push_tx(8'hA2);
      chk1("dem_dreq_lat2", dreq, 1'b1);
      push_tx(8'hA3);
      dack = 1'b1;
      cyc(1);
      ior_pulse("dem1", 8'hA1, 1'b0);
      chk1("dem_dreq_hold1", dreq, 1'b1);
      ior_pulse("dem2", 8'hA2, 1'b0);
      chk1("dem_dreq_hold2", dreq, 1'b1);
      ior_pulse("dem3", 8'hA3, 1'b0);
      chk1("dem_dreq_drop", dreq, 1'b0);
      chk1("dem_oe_off", db_oe, 1'b0);
      chk8("dem_dbout_hold", db_out, 8'hA3);
      dack = 1'b0;
      cyc(2);
      en = 1'b0;
      cyc(1);

      // Single mode, memory-to-device, active-low pins.
      dir = 1'b1;
      mode = 2'b01;
      dreq_pol = 1'b1;
      dack_pol = 1'b1;
      dack = 1'b1;
      cyc(1);
      chk1("sgl_dreq_idle", dreq, 1'b1);
      en = 1'b1;
      cyc(1);
      chk1("sgl_dreq_req", dreq, 1'b0);
      dack = 1'b0;
      cyc(1);
      iow_pulse(8'h5C);
      chk1("sgl_dreq_after", dreq, 1'b1);
      chk1("sgl_rxvalid", rx_valid, 1'b1);
      chk8("sgl_rxdata", rx_data, 8'h5C);
      cyc(3);
      chk1("sgl_no_rereq", dreq, 1'b1);
      dack = 1'b1;
      cyc(1);
      chk1("sgl_idle_gap", dreq, 1'b1);
      cyc(1);
      chk1("sgl_rereq", dreq, 1'b0);
      rx_ready = 1'b1;
      cyc(1);
      rx_ready = 1'b0;
      chk1("sgl_rx_drained", rx_valid, 1'b0);
      en = 1'b0;
      cyc(1);
      chk1("sgl_en_off", dreq, 1'b1);
      cyc(2);

      // Block mode, device-to-memory, 4 bytes.
      dir = 1'b0;
      mode = 2'b10;
      dreq_pol = 1'b0;
      dack_pol = 1'b0;
      dack = 1'b0;
      cyc(1);
      push_tx(8'hB1);
      push_tx(8'hB2);
      push_tx(8'hB3);
      push_tx(8'hB4);
      en = 1'b1;
      cyc(1);
      chk1("blk_dreq_req", dreq, 1'b1);
      dack = 1'b1;
      cyc(1);
      chk1("blk_dreq_drop", dreq, 1'b0);
      ior_pulse("blk1", 8'hB1, 1'b0);
      ior_pulse("blk2", 8'hB2, 1'b0);
      ior_pulse("blk3", 8'hB3, 1'b0);
      ior_pulse("blk4", 8'hB4, 1'b0);
      chk1("blk_err", err, 1'b0);
      chk1("blk_txready", tx_ready, 1'b1);
      dack = 1'b0;
      cyc(3);
      chk1("blk_empty_noreq", dreq, 1'b0);

      // EOP coincident with the second strobe release (demand mode).
      mode = 2'b00;
      push_tx(8'hC1);
      push_tx(8'hC2);
      push_tx(8'hC3);
      dack = 1'b1;
      cyc(1);
      ior_pulse("eop1", 8'hC1, 1'b0);
      ior_pulse("eop2", 8'hC2, 1'b1);
      chk1("eop_tc", tc, 1'b1);
      chk1("eop_dreq", dreq, 1'b0);
      chk8("eop_head", db_out, 8'hC3);
      dack = 1'b0;
      cyc(3);
      chk1("eop_dreq_held", dreq, 1'b0);
      chk1("eop_tc_held", tc, 1'b1);
      en = 1'b0;
      cyc(1);
      chk1("eop_tc_clr", tc, 1'b0);

      // TX underflow.
      dack = 1'b1;
      cyc(1);
      ior_pulse("unf_last", 8'hC3, 1'b0);
      chk1("unf_err_pre", err, 1'b0);
      chk8("unf_dbout_hold", db_out, 8'hC3);
      ior_pulse("unf_extra", 8'hC3, 1'b0);
      chk1("unf_err", err, 1'b1);
      chk8("unf_dbout_zero", db_out, 8'h00);
      dack = 1'b0;
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      chk1("unf_err_rst", err, 1'b0);

      // RX overflow: 9 writes into an 8-deep FIFO.
      dir = 1'b1;
      dack = 1'b1;
      cyc(1);
      for (int i = 0; i < 8; i++) iow_pulse(8'h10 + 8'(i));
      chk1("ovf_err_pre", err, 1'b0);
      iow_pulse(8'hEE);
      chk1("ovf_err", err, 1'b1);
      dack = 1'b0;
      rx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk8("ovf_rxdata", rx_data, 8'h10 + 8'(i));
         cyc(1);
      end
      rx_ready = 1'b0;
      chk1("ovf_rx_empty", rx_valid, 1'b0);

      // Reset in the middle of a transfer.
      dir = 1'b0;
      cyc(1);
      push_tx(8'hD1);
      push_tx(8'hD2);
      push_tx(8'hD3);
      en = 1'b1;
      cyc(1);
      dack = 1'b1;
      cyc(1);
      chk1("rmx_dreq_pre", dreq, 1'b1);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      chk1("rmx_dreq", dreq, 1'b0);
      chk1("rmx_txready", tx_ready, 1'b1);
      chk8("rmx_dbout", db_out, 8'h00);
      chk1("rmx_tc", tc, 1'b0);
      chk1("rmx_err", err, 1'b0);
      cyc(2);
      chk1("rmx_idle", dreq, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total + dir_errs);
      $finish;
   end

endmodule
